lsb_mem_ctrl: RTL and testbench

//  Memory-side responder for the load/store buffer. Accepts one load or store request at a

---
 rtl/lsb_mem_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_lsb_mem_ctrl.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsb_mem_ctrl.sv
// lsb_mem_ctrl: byte-serial RAM/IO responder for the load/store buffer.
// One request in flight; loads return tagged data, stores a done pulse.
module lsb_mem_ctrl #(
   parameter int ID_W   = 4,
   parameter int ADDR_W = 32
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              rdy_in,
   input  logic              flush,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   input  logic [ID_W-1:0]   req_id,
   output logic              mem2lsb_load_en,
   output logic [ID_W-1:0]   mem2lsb_load_id,
   output logic [31:0]       mem2lsb_load_val,
   output logic              mem2lsb_store_en,
   input  logic [7:0]        mem_din,
   output logic [7:0]        mem_dout,
   output logic [ADDR_W-1:0] mem_a,
   output logic              mem_wr,
   input  logic              io_buffer_full
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_STORE,
      S_RESP
   } state_t;

   state_t            r_state;
   state_t            w_state_nx;
   logic [2:0]        r_idx;
   logic [2:0]        w_idx_nx;
   logic [31:0]       r_data;
   logic [31:0]       w_data_nx;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_wdata;
   logic [ID_W-1:0]   r_id;
   logic [1:0]        r_size;
   logic              r_signed;
   logic              r_we;

   logic              w_accept;
   logic [2:0]        w_n;
   logic [1:0]        w_cap;
   logic [2:0]        w_rd_idx;
   logic [2:0]        w_off;
   logic [ADDR_W-1:0] w_cur_addr;
   logic              w_is_io;
   logic              w_wr_go;
   logic [31:0]       w_ext;

   assign req_ready = (r_state == S_IDLE) & rdy_in & ~flush;
   assign w_accept  = req_valid & req_ready;

   always_comb begin
      unique case (r_size)
         2'b00:   w_n = 3'd1;
         2'b01:   w_n = 3'd2;
         default: w_n = 3'd4;
      endcase
   end

   assign w_cap = 2'(r_idx - 3'd1);

   // While stalled, keep presenting the address of the byte still owed,
   // so mem_din holds that byte on the first cycle after resume.
   always_comb begin
      if (rdy_in && (r_idx < w_n)) begin
         w_rd_idx = r_idx;
      end else if (r_idx != 3'd0) begin
         w_rd_idx = r_idx - 3'd1;
      end else begin
         w_rd_idx = 3'd0;
      end
   end

   assign w_off      = (r_state == S_LOAD) ? w_rd_idx : r_idx;
   assign w_cur_addr = r_addr + ADDR_W'(w_off);
   assign w_is_io    = (w_cur_addr[17:16] == 2'b11);
   assign w_wr_go    = (r_state == S_STORE) & rdy_in
                     & ~(w_is_io & io_buffer_full);

   always_comb begin
      unique case (r_size)
         2'b00: w_ext = r_signed ? {{24{r_data[7]}}, r_data[7:0]}
                                 : {24'd0, r_data[7:0]};
         2'b01: w_ext = r_signed ? {{16{r_data[15]}}, r_data[15:0]}
                                 : {16'd0, r_data[15:0]};
         default: w_ext = r_data;
      endcase
   end

   always_comb begin
      w_state_nx = r_state;
      w_idx_nx   = r_idx;
      w_data_nx  = r_data;
      if (rdy_in) begin
         unique case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  w_idx_nx   = 3'd0;
                  w_data_nx  = 32'd0;
                  w_state_nx = req_we ? S_STORE : S_LOAD;
               end
            end
            S_LOAD: begin
               if (flush) begin
                  w_state_nx = S_IDLE;
               end else begin
                  if (r_idx != 3'd0) begin
                     w_data_nx[{w_cap, 3'b000} +: 8] = mem_din;
                  end
                  if (r_idx == w_n) begin
                     w_state_nx = S_RESP;
                  end else begin
                     w_idx_nx = r_idx + 3'd1;
                  end
               end
            end
            S_STORE: begin
               if (w_wr_go) begin
                  if (r_idx == (w_n - 3'd1)) begin
                     w_state_nx = S_RESP;
                  end else begin
                     w_idx_nx = r_idx + 3'd1;
                  end
               end
            end
            S_RESP: begin
               w_state_nx = S_IDLE;
            end
            default: begin
               w_state_nx = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_state  <= S_IDLE;
         r_idx    <= 3'd0;
         r_data   <= 32'd0;
         r_addr   <= '0;
         r_wdata  <= 32'd0;
         r_id     <= '0;
         r_size   <= 2'd0;
         r_signed <= 1'b0;
         r_we     <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_idx   <= w_idx_nx;
         r_data  <= w_data_nx;
         if (w_accept) begin
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            r_id     <= req_id;
            r_size   <= req_size;
            r_signed <= req_signed;
            r_we     <= req_we;
         end
      end
   end

   always_comb begin
      mem_a            = '0;
      mem_dout         = 8'd0;
      mem_wr           = w_wr_go;
      mem2lsb_load_en  = 1'b0;
      mem2lsb_store_en = 1'b0;
      mem2lsb_load_id  = '0;
      mem2lsb_load_val = 32'd0;
      if (r_state == S_LOAD || r_state == S_STORE) begin
         mem_a = w_cur_addr;
      end
      if (r_state == S_STORE) begin
         mem_dout = r_wdata[{r_idx[1:0], 3'b000} +: 8];
      end
      // A flush kills a pending load answer but never a committed store.
      if (r_state == S_RESP && rdy_in) begin
         if (r_we) begin
            mem2lsb_store_en = 1'b1;
         end else if (!flush) begin
            mem2lsb_load_en  = 1'b1;
            mem2lsb_load_id  = r_id;
            mem2lsb_load_val = w_ext;
         end
      end
   end

endmodule

// File: tb/tb_lsb_mem_ctrl.sv
// tb_lsb_mem_ctrl: scoreboard bench with a byte-array reference model
// and a behavioural 8-bit RAM answering the controller.
module tb_lsb_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst_in;
   logic        rdy_in;
   logic        flush;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_id;
   logic        load_en;
   logic [3:0]  load_id;
   logic [31:0] load_val;
   logic        store_en;
   logic [7:0]  mem_din;
   logic [7:0]  mem_dout;
   logic [31:0] mem_a;
   logic        mem_wr;
   logic        io_full;

   lsb_mem_ctrl #(.ID_W(4), .ADDR_W(32)) dut (
      .clk_in           (clk),
      .rst_in           (rst_in),
      .rdy_in           (rdy_in),
      .flush            (flush),
      .req_valid        (req_valid),
      .req_ready        (req_ready),
      .req_we           (req_we),
      .req_size         (req_size),
      .req_signed       (req_signed),
      .req_addr         (req_addr),
      .req_wdata        (req_wdata),
      .req_id           (req_id),
      .mem2lsb_load_en  (load_en),
      .mem2lsb_load_id  (load_id),
      .mem2lsb_load_val (load_val),
      .mem2lsb_store_en (store_en),
      .mem_din          (mem_din),
      .mem_dout         (mem_dout),
      .mem_a            (mem_a),
      .mem_wr           (mem_wr),
      .io_buffer_full   (io_full)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          st;
      logic [3:0]  id;
      logic [31:0] val;
      int          acc;
      int          lat;
   } rsp_t;

   typedef struct {
      logic [31:0] a;
      logic [7:0]  d;
   } wr_t;

   rsp_t sb[$];
   wr_t  wq[$];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   bit   rand_env = 0;

   bit [7:0] sim_ram [16384];
   bit       sim_vld [16384];
   bit [7:0] ref_ram [16384];
   bit       ref_vld [16384];

   function automatic logic [13:0] ix(input logic [31:0] a);
      return {a[17:16], a[11:0]};
   endfunction

   function automatic logic [7:0] pat(input logic [13:0] i);
      return i[7:0] ^ {i[13:8], 2'b01};
   endfunction

   function automatic logic [7:0] ref_rd(input logic [31:0] a);
      return ref_vld[ix(a)] ? ref_ram[ix(a)] : pat(ix(a));
   endfunction

   function automatic int nbytes(input logic [1:0] sz);
      return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
   endfunction

   function automatic logic [31:0] ref_load(input logic [31:0] a,
                                            input logic [1:0]  sz,
                                            input logic        sg);
      int     n;
      longint v;
      n = nbytes(sz);
      v = 0;
      for (int i = 0; i < n; i++)
         v += longint'(ref_rd(a + 32'(i))) << (8 * i);
      if (sg && n < 4 && v >= (longint'(1) << (8 * n - 1)))
         v -= longint'(1) << (8 * n);
      return v[31:0];
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      mem_din <= sim_vld[ix(mem_a)] ? sim_ram[ix(mem_a)] : pat(ix(mem_a));
      if (mem_wr) begin
         sim_ram[ix(mem_a)] <= mem_dout;
         sim_vld[ix(mem_a)] <= 1'b1;
      end
   end

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic flag(input string nm);
      total++;
      bad++;
      $display("FAIL %s (cyc %0d)", nm, cyc);
   endtask

   task automatic tick();
      @(negedge clk);
      if (rand_env) begin
         rdy_in  = ($urandom_range(0, 4) != 0);
         io_full = ($urandom_range(0, 3) == 0);
      end
   endtask

   task automatic issue(input logic we, input logic [1:0] sz,
                        input logic sg, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] id,
                        input int lat, input bit exp_rsp);
      int   w;
      int   n;
      rsp_t e;
      w = 0;
      tick();
      req_valid  = 1'b1;
      req_we     = we;
      req_size   = sz;
      req_signed = sg;
      req_addr   = a;
      req_wdata  = wd;
      req_id     = id;
      #1;
      while (!req_ready && w < 200) begin
         tick();
         #1;
         w++;
      end
      if (!req_ready) begin
         flag("accept timeout");
         req_valid = 1'b0;
         return;
      end
      n = nbytes(sz);
      e.st  = we;
      e.id  = id;
      e.acc = cyc;
      e.lat = lat;
      e.val = 32'd0;
      if (we) begin
         for (int i = 0; i < n; i++) begin
            wr_t   x;
            x.a = a + 32'(i);
            x.d = 8'(wd >> (8 * i));
            ref_ram[ix(x.a)] = x.d;
            ref_vld[ix(x.a)] = 1'b1;
            wq.push_back(x);
         end
      end else begin
         e.val = ref_load(a, sz, sg);
      end
      if (exp_rsp) sb.push_back(e);
      tick();
      req_valid  = 1'b0;
      req_we     = 1'($urandom);
      req_size   = 2'($urandom);
      req_signed = 1'($urandom);
      req_addr   = $urandom;
      req_wdata  = $urandom;
      req_id     = 4'($urandom);
   endtask

   task automatic wait_done();
      int k;
      k = 0;
      while ((sb.size() != 0 || wq.size() != 0) && k < 300) begin
         tick();
         #3;
         k++;
      end
      if (sb.size() != 0 || wq.size() != 0) begin
         flag("response timeout");
         sb.delete();
         wq.delete();
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (!rst_in) begin
            if (mem_wr) begin
               if (wq.size() == 0) begin
                  flag("unexpected mem_wr");
               end else begin
                  wr_t w;
                  w = wq.pop_front();
                  chk("wr_addr", 64'(mem_a), 64'(w.a));
                  chk("wr_data", 64'(mem_dout), 64'(w.d));
               end
            end
            if (load_en && store_en) begin
               flag("load_en and store_en together");
            end else if (load_en || store_en) begin
               if (sb.size() == 0) begin
                  flag("unexpected response");
               end else begin
                  rsp_t e;
                  e = sb.pop_front();
                  chk("resp_kind", 64'(store_en), 64'(e.st));
                  if (load_en) begin
                     chk("load_id", 64'(load_id), 64'(e.id));
                     chk("load_val", 64'(load_val), 64'(e.val));
                  end
                  if (e.lat >= 0)
                     chk("latency", 64'(cyc - e.acc), 64'(e.lat));
               end
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_in     = 1'b1;
      rdy_in     = 1'b1;
      flush      = 1'b0;
      io_full    = 1'b0;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_size   = 2'd0;
      req_signed = 1'b0;
      req_addr   = 32'd0;
      req_wdata  = 32'd0;
      req_id     = 4'd0;
      #3;
      chk("rst_mem_wr", 64'(mem_wr), 64'd0);
      chk("rst_mem_a", 64'(mem_a), 64'd0);
      chk("rst_mem_dout", 64'(mem_dout), 64'd0);
      chk("rst_load_en", 64'(load_en), 64'd0);
      chk("rst_store_en", 64'(store_en), 64'd0);
      chk("rst_load_val", 64'(load_val), 64'd0);
      tick();
      tick();
      rst_in = 1'b0;

      issue(1'b1, 2'b10, 1'b0, 32'h100, 32'h4433_2211, 4'h1, 5, 1'b1);
      wait_done();
      issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 4'h7, 6, 1'b1);
      wait_done();
      issue(1'b1, 2'b00, 1'b0, 32'h180, 32'h1234_5680, 4'h2, 2, 1'b1);
      wait_done();
      issue(1'b0, 2'b00, 1'b1, 32'h180, 32'h0, 4'h3, 3, 1'b1);
      issue(1'b0, 2'b00, 1'b0, 32'h180, 32'h0, 4'h4, 3, 1'b1);
      wait_done();
      issue(1'b1, 2'b01, 1'b0, 32'h200, 32'hDEAD_BEEF, 4'h5, 3, 1'b1);
      wait_done();
      issue(1'b0, 2'b01, 1'b1, 32'h200, 32'h0, 4'h6, 4, 1'b1);
      issue(1'b0, 2'b11, 1'b1, 32'h100, 32'h0, 4'h8, 6, 1'b1);
      wait_done();

      io_full = 1'b1;
      issue(1'b1, 2'b00, 1'b0, 32'h3_0000, 32'h0000_00A5, 4'h6, -1, 1'b1);
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("io_hold_wr", 64'(mem_wr), 64'd0);
         tick();
      end
      io_full = 1'b0;
      wait_done();
      issue(1'b0, 2'b00, 1'b0, 32'h3_0000, 32'h0, 4'h9, 3, 1'b1);
      wait_done();

      issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 4'h8, -1, 1'b0);
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      #1;
      chk("flush_ready", 64'(req_ready), 64'd1);
      repeat (8) tick();

      issue(1'b1, 2'b10, 1'b0, 32'h220, 32'hCAFE_F00D, 4'h9, 5, 1'b1);
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      wait_done();
      issue(1'b0, 2'b10, 1'b0, 32'h220, 32'h0, 4'hC, 6, 1'b1);
      wait_done();

      issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 4'hA, -1, 1'b1);
      tick();
      rdy_in = 1'b0;
      repeat (3) tick();
      rdy_in = 1'b1;
      wait_done();

      issue(1'b0, 2'b10, 1'b0, 32'hFFFF_FFFE, 32'h0, 4'hB, 6, 1'b1);
      wait_done();

      rand_env = 1;
      for (int t = 0; t < 60; t++) begin
         logic [31:0] a;
         case ($urandom_range(0, 3))
            0: a = 32'h1000 + 32'($urandom_range(0, 63));
            1: a = 32'h3_0000 + 32'($urandom_range(0, 15));
            2: a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
            default: a = 32'h100 + 32'($urandom_range(0, 255));
         endcase
         issue(1'($urandom), 2'($urandom), 1'($urandom), a,
               $urandom, 4'($urandom), -1, 1'b1);
      end
      rand_env = 0;
      rdy_in   = 1'b1;
      io_full  = 1'b0;
      wait_done();

      issue(1'b1, 2'b10, 1'b0, 32'h400, 32'h0102_0304, 4'hD, 5, 1'b1);
      tick();
      #3;
      rst_in = 1'b1;
      sb.delete();
      wq.delete();
      #1;
      chk("midrst_mem_wr", 64'(mem_wr), 64'd0);
      chk("midrst_mem_a", 64'(mem_a), 64'd0);
      chk("midrst_mem_dout", 64'(mem_dout), 64'd0);
      chk("midrst_store_en", 64'(store_en), 64'd0);
      chk("midrst_load_en", 64'(load_en), 64'd0);
      tick();
      tick();
      rst_in = 1'b0;
      repeat (8) tick();
      issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 4'hE, 6, 1'b1);
      wait_done();
      repeat (4) tick();
      chk("sb_empty", 64'(sb.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
